// File: rtl/tcp_frame_builder_pkg.sv
// Shared definitions for the TCP transmit frame builder: protocol constants,
// FSM encoding, the latched header record and the TCP flag bit positions.
package tcp_frame_builder_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_TCP   = 8'h06;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;
  localparam logic [7:0]  TCP_DATA_OFF   = 8'h50;

  localparam int ETH_HDR_BYTES   = 14;
  localparam int IP_HDR_BYTES    = 20;
  localparam int TCP_HDR_BYTES   = 20;
  localparam int FRAME_HDR_BYTES = ETH_HDR_BYTES + IP_HDR_BYTES + TCP_HDR_BYTES;
  localparam int LAST_HDR_BEAT   = 5;

  // tcp_flags bit positions, shared with the receive parser
  localparam int TCP_FLAG_FIN = 0;
  localparam int TCP_FLAG_SYN = 1;
  localparam int TCP_FLAG_RST = 2;
  localparam int TCP_FLAG_PSH = 3;
  localparam int TCP_FLAG_ACK = 4;
  localparam int TCP_FLAG_URG = 5;
  localparam int TCP_FLAG_ECE = 6;
  localparam int TCP_FLAG_CWR = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREP    = 3'd1,
    ST_HDR     = 3'd2,
    ST_MERGE   = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_TAIL    = 3'd5
  } state_t;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] ip_id;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [7:0]  tcp_flags;
    logic [15:0] window;
    logic [15:0] payload_len;
  } hdr_t;

  // Byte-keep mask for the final payload word; tail_bytes = L mod 8 (0 = full word)
  function automatic logic [63:0] keep_mask(input logic [2:0] tail_bytes);
    logic [63:0] ones;
    ones = '1;
    if (tail_bytes == 3'd0) return ones;
    return ~(ones >> (8 * int'(tail_bytes)));
  endfunction

endpackage

// File: rtl/tcp_frame_builder_csum.sv
// ipv4_csum16: combinational IPv4 header checksum. Sums the ten 16-bit header
// words (checksum field supplied as zero), folds end-around carries, inverts.
module ipv4_csum16
  import tcp_frame_builder_pkg::*;
(
  input  logic [IP_HDR_BYTES*8-1:0] words,
  output logic [15:0]               csum
);

  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // One's-complement sum of the header words, then two carry folds
  always_comb begin
    // NOTE: blocking assignments here because each line reads the value the
    // previous line just produced; combinational blocks always use '='.
    sum = '0;
    for (int i = 0; i < IP_HDR_BYTES / 2; i++) begin
      sum = sum + {4'h0, words[i*16 +: 16]};
    end
    fold1 = {1'b0, sum[15:0]} + {13'h0, sum[19:16]};
    fold2 = fold1[15:0] + {15'h0, fold1[16]};
    csum  = ~fold2;
  end

endmodule

// File: rtl/tcp_frame_builder.sv
// tcp_frame_builder: serialises one Ethernet II / IPv4 / TCP frame as 64-bit
// big-endian beats. The 54-byte header leaves payload 6 bytes into beat 6, so
// each payload word is split: top 2 bytes finish the current beat, low 6 bytes
// are carried into the next one.
// Build option: define IPV4_CSUM_EN to fill in the IPv4 header checksum;
// otherwise the checksum field is zero. PREP lasts one cycle either way.
module tcp_frame_builder
  import tcp_frame_builder_pkg::*;
#(
  parameter int          MAX_PAYLOAD    = 1460,
  parameter logic [7:0]  IP_TTL         = 8'h40,
  parameter logic [15:0] TCP_WINDOW_DEF = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_busy,
  output logic        req_err,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  input  logic [15:0] ip_id,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic [31:0] seq_num,
  input  logic [31:0] ack_num,
  input  logic [7:0]  tcp_flags,
  input  logic [15:0] req_window,
  input  logic [15:0] payload_len,
  input  logic [63:0] pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [63:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic [2:0]  tx_empty
);

  state_t      state, state_nxt;
  hdr_t        hdr;
  logic [15:0] ip_csum, csum_calc, ip_len;
  logic [15:0] len_words, len_beats;
  logic [2:0]  frame_tail, hdr_cnt, eop_empty;
  logic [7:0]  beat_idx, consumed, n_pl, n_tx;
  logic [47:0] carry;
  logic [63:0] hdr_beat, pl_word, beat_data;
  logic        can_load, req_ok, accept, reject;
  logic        words_left, last_word, emit, consume, beat_sop, beat_eop;

  assign can_load   = !tx_valid || tx_ready;
  assign req_busy   = (state != ST_IDLE) || tx_valid;
  assign req_ok     = (state == ST_IDLE) && !tx_valid && req_valid;
  assign accept     = req_ok && (payload_len <= 16'(MAX_PAYLOAD));
  assign reject     = req_ok && (payload_len >  16'(MAX_PAYLOAD));
  assign len_words  = (payload_len + 16'd7) >> 3;
  assign len_beats  = (payload_len + 16'(FRAME_HDR_BYTES + 7)) >> 3;
  assign frame_tail = payload_len[2:0] + 3'(FRAME_HDR_BYTES);
  assign ip_len     = 16'(IP_HDR_BYTES + TCP_HDR_BYTES) + hdr.payload_len;
  assign words_left = consumed < n_pl;
  assign last_word  = (consumed + 8'd1) == n_pl;
  // Bytes past L in the final word are cleared so padding is always zero
  assign pl_word    = last_word ? (pl_data & keep_mask(hdr.payload_len[2:0])) : pl_data;

`ifdef IPV4_CSUM_EN
  ipv4_csum16 u_csum (
    .words ({IP_VER_IHL, 8'h00, ip_len, hdr.ip_id, IP_FLAGS_DF, IP_TTL,
             IP_PROTO_TCP, 16'h0000, hdr.src_ip, hdr.dst_ip}),
    .csum  (csum_calc)
  );
`else
  assign csum_calc = 16'h0000;
`endif

  // Select the header beat addressed by the header counter
  always_comb begin
    case (hdr_cnt)
      3'd0:    hdr_beat = {hdr.dst_mac, hdr.src_mac[47:32]};
      3'd1:    hdr_beat = {hdr.src_mac[31:0], ETHERTYPE_IPV4, IP_VER_IHL, 8'h00};
      3'd2:    hdr_beat = {ip_len, hdr.ip_id, IP_FLAGS_DF, IP_TTL, IP_PROTO_TCP};
      3'd3:    hdr_beat = {ip_csum, hdr.src_ip, hdr.dst_ip[31:16]};
      3'd4:    hdr_beat = {hdr.dst_ip[15:0], hdr.src_port, hdr.dst_port, hdr.seq_num[31:16]};
      default: hdr_beat = {hdr.seq_num[15:0], hdr.ack_num, TCP_DATA_OFF, hdr.tcp_flags};
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    // NOTE: registers update with '<=' so every flop samples pre-edge values,
    // independent of statement order across blocks.
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_PREP;
      ST_PREP: state_nxt = ST_HDR;
      ST_HDR:  if (emit && hdr_cnt == 3'(LAST_HDR_BEAT)) state_nxt = ST_MERGE;
      ST_MERGE, ST_PAYLOAD: begin
        if (emit) begin
          if (beat_eop)                 state_nxt = ST_IDLE;
          else if (consume && last_word) state_nxt = ST_TAIL;
          else                          state_nxt = ST_PAYLOAD;
        end
      end
      ST_TAIL: if (emit) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: payload handshake and the beat offered to the output register
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    pl_ready  = 1'b0;
    emit      = 1'b0;
    consume   = 1'b0;
    beat_data = '0;
    beat_sop  = 1'b0;
    case (state)
      ST_HDR: begin
        emit      = can_load;
        beat_data = hdr_beat;
        beat_sop  = (hdr_cnt == 3'd0);
      end
      ST_MERGE: begin
        if (words_left) begin
          pl_ready  = can_load;
          emit      = can_load && pl_valid;
          consume   = emit;
          beat_data = {hdr.window, 16'h0000, 16'h0000, pl_word[63:48]};
        end else begin
          emit      = can_load;
          beat_data = {hdr.window, 16'h0000, 16'h0000, 16'h0000};
        end
      end
      ST_PAYLOAD: begin
        pl_ready  = can_load && words_left;
        emit      = pl_ready && pl_valid;
        consume   = emit;
        beat_data = {carry, pl_word[63:48]};
      end
      ST_TAIL: begin
        emit      = can_load;
        beat_data = {carry, 16'h0000};
      end
      default: ;
    endcase
    beat_eop = emit && (beat_idx == n_tx - 8'd1);
  end

  // Output register, error pulse and frame progress counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
      tx_sop   <= 1'b0;
      tx_eop   <= 1'b0;
      tx_empty <= '0;
      req_err  <= 1'b0;
      hdr_cnt  <= '0;
      beat_idx <= '0;
      consumed <= '0;
    end else begin
      req_err <= reject;
      if (can_load) begin
        tx_valid <= emit;
        tx_sop   <= beat_sop;
        tx_eop   <= beat_eop;
        tx_empty <= beat_eop ? eop_empty : 3'd0;
        if (emit) tx_data <= beat_data;
      end
      if (accept) begin
        hdr_cnt  <= '0;
        beat_idx <= '0;
        consumed <= '0;
      end else begin
        if (emit)                     beat_idx <= beat_idx + 8'd1;
        if (emit && state == ST_HDR)  hdr_cnt  <= hdr_cnt + 3'd1;
        if (consume)                  consumed <= consumed + 8'd1;
      end
    end
  end

  // Header latch, checksum and payload carry
  always_ff @(posedge clk) begin
    // NOTE: pure datapath registers are not reset; they are always written
    // (accept / PREP / consume) before the FSM reads them.
    if (accept) begin
      hdr <= '{dst_mac:     dst_mac,
               src_mac:     src_mac,
               src_ip:      src_ip,
               dst_ip:      dst_ip,
               ip_id:       ip_id,
               src_port:    src_port,
               dst_port:    dst_port,
               seq_num:     seq_num,
               ack_num:     ack_num,
               tcp_flags:   tcp_flags,
               window:      (req_window == 16'h0000) ? TCP_WINDOW_DEF : req_window,
               payload_len: payload_len};
      n_pl      <= 8'(len_words);
      n_tx      <= 8'(len_beats);
      eop_empty <= 3'd0 - frame_tail;
    end
    if (state == ST_PREP) ip_csum <= csum_calc;
    if (consume)          carry   <= pl_word[47:0];
  end

endmodule

// File: tb/tb_tcp_frame_builder.sv
// Self-checking bench for tcp_frame_builder: the expected frame is assembled
// byte by byte from the header fields and payload, then cut into 8-byte beats.
module tb_tcp_frame_builder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_busy, req_err;
  logic [47:0] dst_mac, src_mac;
  logic [31:0] src_ip, dst_ip, seq_num, ack_num;
  logic [15:0] ip_id, src_port, dst_port, req_window, payload_len;
  logic [7:0]  tcp_flags;
  logic [63:0] pl_data, tx_data;
  logic        pl_valid, pl_ready, tx_valid, tx_ready, tx_sop, tx_eop;
  logic [2:0]  tx_empty;

  always #5 clk = ~clk;

  tcp_frame_builder dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_busy(req_busy),
    .req_err(req_err), .dst_mac(dst_mac), .src_mac(src_mac), .src_ip(src_ip),
    .dst_ip(dst_ip), .ip_id(ip_id), .src_port(src_port), .dst_port(dst_port),
    .seq_num(seq_num), .ack_num(ack_num), .tcp_flags(tcp_flags),
    .req_window(req_window), .payload_len(payload_len), .pl_data(pl_data),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .tx_empty(tx_empty)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  fb[$];
  logic [63:0] exp_beats[$];
  logic [63:0] got_beats[$];
  logic [63:0] pl_words[$];
  int          exp_empty;

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic void push_be(input logic [63:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) fb.push_back(v[i*8 +: 8]);
  endfunction

  task automatic scramble_fields();
    dst_mac     = 48'(rand64());
    src_mac     = 48'(rand64());
    src_ip      = $urandom();
    dst_ip      = $urandom();
    ip_id       = 16'($urandom());
    src_port    = 16'($urandom());
    dst_port    = 16'($urandom());
    seq_num     = $urandom();
    ack_num     = $urandom();
    tcp_flags   = 8'($urandom());
    req_window  = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom());
    payload_len = 16'($urandom());
  endtask

  // Reference frame from the currently driven fields and pl_words
  task automatic build_model(input int len);
    logic [31:0] sum;
    logic [15:0] win;
    int          nb;
    logic [63:0] w;
    fb.delete();
    exp_beats.delete();
    win = (req_window == 16'h0000) ? 16'hFFFF : req_window;
    push_be(64'(dst_mac), 6);
    push_be(64'(src_mac), 6);
    push_be(64'h0800, 2);
    push_be(64'h4500, 2);
    push_be(64'(40 + len), 2);
    push_be(64'(ip_id), 2);
    push_be(64'h4000, 2);
    push_be(64'h4006, 2);
    push_be(64'h0000, 2);
    push_be(64'(src_ip), 4);
    push_be(64'(dst_ip), 4);
    push_be(64'(src_port), 2);
    push_be(64'(dst_port), 2);
    push_be(64'(seq_num), 4);
    push_be(64'(ack_num), 4);
    push_be(64'h50, 1);
    push_be(64'(tcp_flags), 1);
    push_be(64'(win), 2);
    push_be(64'h0, 4);
    sum = 0;
    for (int i = 0; i < 10; i++) sum = sum + {16'h0, fb[14 + 2*i], fb[15 + 2*i]};
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    sum = ~sum;
`ifdef IPV4_CSUM_EN
    fb[24] = sum[15:8];
    fb[25] = sum[7:0];
`endif
    for (int k = 0; k < len; k++) begin
      w = pl_words[k / 8];
      fb.push_back(w[63 - 8*(k % 8) -: 8]);
    end
    nb = fb.size();
    for (int b = 0; b < (nb + 7) / 8; b++) begin
      w = '0;
      for (int k = 0; k < 8; k++)
        if (8*b + k < nb) w[63 - 8*k -: 8] = fb[8*b + k];
      exp_beats.push_back(w);
    end
    exp_empty = (8 - nb % 8) % 8;
  endtask

  // Issues one request at the current negedge phase and collects its frame
  task automatic run_frame(input int len, input int stall_pct, input int gap_pct,
                           input bit fixed_ip, input string name);
    int          pl_idx, cyc, idx, nexp;
    bit          done, hold, ready_seen, err_seen;
    logic [63:0] snap_data;
    logic [5:0]  snap_ctl;
    logic [4:0]  e_ctl;
    scramble_fields();
    payload_len = 16'(len);
    if (fixed_ip) begin
      src_ip = 32'hC0A80001;
      dst_ip = 32'hC0A800C7;
      ip_id  = 16'h0000;
    end
    pl_words.delete();
    for (int i = 0; i < (len + 7) / 8; i++) pl_words.push_back(rand64());
    build_model(len);
    nexp = exp_beats.size();
    got_beats.delete();
    req_valid = 1'b1;
    tx_ready  = 1'b1;
    pl_valid  = 1'b0;
    pl_idx = 0; cyc = 0; done = 0; hold = 0; ready_seen = 0; err_seen = 0;
    snap_data = '0; snap_ctl = '0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      // Fields and stray requests change freely while busy
      scramble_fields();
      req_valid = $urandom_range(1);
      tx_ready  = ($urandom_range(99) >= stall_pct);
      pl_valid  = (pl_idx < pl_words.size()) && ($urandom_range(99) >= gap_pct);
      pl_data   = pl_valid ? pl_words[pl_idx] : rand64();
      #1;
      if (cyc == 1) begin
        n_cmp++;
        if (req_busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s busy_after_accept: got %b want 1", name, req_busy);
        end
      end
      if (hold) begin
        n_cmp++;
        if (tx_data !== snap_data || {tx_valid, tx_sop, tx_eop, tx_empty} !== snap_ctl) begin
          n_err++;
          $display("FAIL %s stall_hold: got %h/%b want %h/%b", name, tx_data,
                   {tx_valid, tx_sop, tx_eop, tx_empty}, snap_data, snap_ctl);
        end
      end
      if (req_err) err_seen = 1;
      if (pl_ready) ready_seen = 1;
      if (pl_valid && pl_ready) pl_idx++;
      if (tx_valid && tx_ready) begin
        idx = got_beats.size();
        n_cmp++;
        if (idx >= nexp) begin
          n_err++;
          $display("FAIL %s extra_beat %0d: got %h want none", name, idx, tx_data);
        end else begin
          e_ctl = {idx == 0, idx == nexp - 1, (idx == nexp - 1) ? 3'(exp_empty) : 3'd0};
          if (tx_data !== exp_beats[idx] || {tx_sop, tx_eop, tx_empty} !== e_ctl) begin
            n_err++;
            $display("FAIL %s beat %0d: got %h sop/eop/empty=%b want %h %b", name, idx,
                     tx_data, {tx_sop, tx_eop, tx_empty}, exp_beats[idx], e_ctl);
          end
        end
        got_beats.push_back(tx_data);
        if (tx_eop) done = 1;
      end
      hold      = tx_valid && !tx_ready;
      snap_data = tx_data;
      snap_ctl  = {tx_valid, tx_sop, tx_eop, tx_empty};
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s timeout: got %0d beats want %0d", name, got_beats.size(), nexp);
    end
    @(negedge clk);
    req_valid = 1'b0;
    tx_ready  = 1'b1;
    pl_valid  = 1'b0;
    #1;
    n_cmp++;
    if (req_busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy_drop: got %b want 0", name, req_busy);
    end
    n_cmp++;
    if (got_beats.size() != nexp) begin
      n_err++;
      $display("FAIL %s beat_count: got %0d want %0d", name, got_beats.size(), nexp);
    end
    n_cmp++;
    if (pl_idx != pl_words.size()) begin
      n_err++;
      $display("FAIL %s words_consumed: got %0d want %0d", name, pl_idx, pl_words.size());
    end
    n_cmp++;
    if (err_seen) begin
      n_err++;
      $display("FAIL %s err_while_busy: got 1 want 0", name);
    end
    if (len == 0) begin
      n_cmp++;
      if (ready_seen) begin
        n_err++;
        $display("FAIL %s pl_ready_l0: got 1 want 0", name);
      end
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 1'b0;
    tx_ready  = 1'b1;
    pl_valid  = 1'b0;
    pl_data   = '0;
    scramble_fields();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({tx_valid, tx_sop, tx_eop, tx_empty, req_busy, req_err, pl_ready} !== 9'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want 0",
               {tx_valid, tx_sop, tx_eop, tx_empty, req_busy, req_err, pl_ready});
    end
    n_cmp++;
    if (tx_data !== 64'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0", tx_data);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_empty_payload();
    logic [63:0] b;
    run_frame(0, 0, 0, 1'b1, "l0");
    if (got_beats.size() >= 4) begin
      b = got_beats[2];
      n_cmp++;
      if (b[63:48] !== 16'h0028) begin
        n_err++;
        $display("FAIL l0_ip_len: got %h want 0028", b[63:48]);
      end
`ifdef IPV4_CSUM_EN
      b = got_beats[3];
      n_cmp++;
      if (b[63:48] !== 16'hB8B7) begin
        n_err++;
        $display("FAIL l0_ip_csum: got %h want b8b7", b[63:48]);
      end
`endif
    end
  endtask

  task automatic test_short_payloads();
    run_frame(2, 0, 0, 1'b0, "l2");
    run_frame(3, 0, 30, 1'b0, "l3");
  endtask

  task automatic test_stall();
    run_frame(18, 50, 0, 1'b0, "l18_stall");
    run_frame(18, 50, 40, 1'b0, "l18_stall_gap");
  endtask

  task automatic test_oversize();
    int err_cnt = 0;
    bit bad = 0;
    scramble_fields();
    payload_len = 16'd1461;
    req_valid   = 1'b1;
    tx_ready    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      if (req_err) err_cnt++;
      if (req_busy || tx_valid) bad = 1;
    end
    n_cmp++;
    if (err_cnt != 1) begin
      n_err++;
      $display("FAIL oversize_err: got %0d pulses want 1", err_cnt);
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL oversize_idle: got busy/valid 1 want 0");
    end
  endtask

  task automatic test_random();
    int lens[6] = '{1, 7, 8, 9, 14, 1460};
    foreach (lens[i]) run_frame(lens[i], 30, 30, 1'b0, "rand_edge");
    for (int i = 0; i < 4; i++) run_frame($urandom_range(200), 30, 30, 1'b0, "rand_len");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) run_frame($urandom_range(40), 0, 0, 1'b0, "b2b");
  endtask

  task automatic test_mid_reset();
    int beats = 0;
    int cyc = 0;
    bit hit = 0;
    bit eop_seen = 0;
    scramble_fields();
    payload_len = 16'd100;
    req_valid   = 1'b1;
    tx_ready    = 1'b1;
    while (!hit && cyc < 200) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      pl_valid  = 1'b1;
      pl_data   = rand64();
      #1;
      if (tx_valid && tx_eop) eop_seen = 1;
      if (tx_valid && beats == 4) begin
        hit     = 1;
        reset_n = 1'b0;
      end else if (tx_valid && tx_ready) begin
        beats++;
      end
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL mid_reset_reach_beat4: got %0d beats want 4", beats);
    end
    @(negedge clk);
    pl_valid = 1'b0;
    #1;
    n_cmp++;
    if ({tx_valid, tx_sop, tx_eop, req_busy, pl_ready} !== 5'b0) begin
      n_err++;
      $display("FAIL mid_reset_idle: got %b want 0", {tx_valid, tx_sop, tx_eop, req_busy, pl_ready});
    end
    n_cmp++;
    if (eop_seen) begin
      n_err++;
      $display("FAIL mid_reset_no_eop: got 1 want 0");
    end
    reset_n = 1'b1;
    run_frame($urandom_range(120), 20, 20, 1'b0, "after_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_empty_payload();
    test_short_payloads();
    test_stall();
    test_oversize();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
